// File: rtl/mole_hit_judge_if.sv
// Player-facing signal bundle for the whack-a-mole judge.
// The master drives start/key_pos; the slave is the judge itself.
interface mole_hit_judge_if;
    logic       start;
    logic [3:0] key_pos;
    logic [8:0] mole_map;
    logic [9:0] score;
    logic [3:0] miss_cnt;
    logic       hit_pulse;
    logic       miss_pulse;
    logic [1:0] game_state;

    modport master (
        output start, key_pos,
        input  mole_map, score, miss_cnt, hit_pulse, miss_pulse, game_state
    );

    modport slave (
        input  start, key_pos,
        output mole_map, score, miss_cnt, hit_pulse, miss_pulse, game_state
    );
endinterface

// File: rtl/mole_hit_judge.sv
// Whack-a-mole judge: LFSR-driven mole spawning, per-hole life timers,
// hit/miss scoring and a three-state game FSM. All outputs registered.
module mole_hit_judge #(
    parameter int unsigned SPAWN_CYCLES = 25_000_000,
    parameter int unsigned LIFE_CYCLES  = 50_000_000,
    parameter int unsigned MAX_MISS     = 5
) (
    input  logic            clk,
    input  logic            rst,
    mole_hit_judge_if.slave bus
);
    localparam int unsigned SW = (SPAWN_CYCLES > 1) ? $clog2(SPAWN_CYCLES) : 1;
    localparam int unsigned TW = (LIFE_CYCLES > 1) ? $clog2(LIFE_CYCLES) : 1;
    localparam logic [SW-1:0] SPAWN_LAST = SW'(SPAWN_CYCLES - 1);
    localparam logic [TW-1:0] LIFE_LOAD  = TW'(LIFE_CYCLES - 1);
    localparam logic [9:0]    SCORE_MAX  = 10'd999;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      lfsr_q, lfsr_d;
    logic [SW-1:0]   spawn_cnt_q, spawn_cnt_d;
    logic [TW-1:0]   timer_q [9];
    logic [TW-1:0]   timer_d [9];
    logic [8:0]      mole_map_q, mole_map_d;
    logic [9:0]      score_q, score_d;
    logic [3:0]      miss_cnt_q, miss_cnt_d;
    logic            hit_pulse_q, hit_pulse_d;
    logic            miss_pulse_q, miss_pulse_d;

    logic [3:0]      target;
    logic [3:0]      expire_cnt;
    logic [4:0]      miss_sum;

    always_comb begin
        lfsr_d       = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        state_d      = state_q;
        spawn_cnt_d  = spawn_cnt_q;
        timer_d      = timer_q;
        mole_map_d   = mole_map_q;
        score_d      = score_q;
        miss_cnt_d   = miss_cnt_q;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;
        target       = 4'(lfsr_q % 8'd9);
        expire_cnt   = '0;
        miss_sum     = '0;

        case (state_q)
            IDLE, OVER: begin
                if (bus.start) begin
                    state_d     = PLAY;
                    spawn_cnt_d = '0;
                    timer_d     = '{default: '0};
                    mole_map_d  = '0;
                    score_d     = '0;
                    miss_cnt_d  = '0;
                end
            end
            PLAY: begin
                spawn_cnt_d = (spawn_cnt_q == SPAWN_LAST) ? '0 : spawn_cnt_q + SW'(1);

                // A key on a hole whose timer is also expiring counts as a hit only.
                for (int unsigned i = 0; i < 9; i++) begin
                    if (mole_map_q[4'(i)]) begin
                        if (bus.key_pos == 4'(i)) begin
                            mole_map_d[4'(i)] = 1'b0;
                            timer_d[4'(i)]    = '0;
                            hit_pulse_d       = 1'b1;
                        end else if (timer_q[4'(i)] == '0) begin
                            mole_map_d[4'(i)] = 1'b0;
                            expire_cnt        = expire_cnt + 4'd1;
                        end else begin
                            timer_d[4'(i)] = timer_q[4'(i)] - TW'(1);
                        end
                    end
                end

                // Occupancy is judged on the pre-edge map, so a same-cycle hit blocks the spawn.
                if (spawn_cnt_q == SPAWN_LAST && !mole_map_q[target]) begin
                    mole_map_d[target] = 1'b1;
                    timer_d[target]    = LIFE_LOAD;
                end

                if (hit_pulse_d && score_q != SCORE_MAX) begin
                    score_d = score_q + 10'd1;
                end

                miss_sum     = {1'b0, miss_cnt_q} + {1'b0, expire_cnt};
                miss_cnt_d   = (miss_sum > 5'd15) ? 4'd15 : miss_sum[3:0];
                miss_pulse_d = (expire_cnt != '0);

                if (32'(miss_sum) >= MAX_MISS) begin
                    state_d     = OVER;
                    mole_map_d  = '0;
                    timer_d     = '{default: '0};
                    spawn_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            lfsr_q       <= 8'hA5;
            spawn_cnt_q  <= '0;
            timer_q      <= '{default: '0};
            mole_map_q   <= '0;
            score_q      <= '0;
            miss_cnt_q   <= '0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            spawn_cnt_q  <= spawn_cnt_d;
            timer_q      <= timer_d;
            mole_map_q   <= mole_map_d;
            score_q      <= score_d;
            miss_cnt_q   <= miss_cnt_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
        end
    end

    assign bus.mole_map   = mole_map_q;
    assign bus.score      = score_q;
    assign bus.miss_cnt   = miss_cnt_q;
    assign bus.hit_pulse  = hit_pulse_q;
    assign bus.miss_pulse = miss_pulse_q;
    assign bus.game_state = state_q;
endmodule

// File: tb/tb_mole_hit_judge.sv
// Directed bench for mole_hit_judge with SPAWN_CYCLES=4, LIFE_CYCLES=8, MAX_MISS=3.
// Spawn targets are predicted from an independent LFSR reference.
module tb_mole_hit_judge;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    logic [7:0] m_lfsr;

    mole_hit_judge_if bus ();

    mole_hit_judge #(
        .SPAWN_CYCLES(4),
        .LIFE_CYCLES (8),
        .MAX_MISS    (3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference LFSR for x^8+x^6+x^5+x^4+1, seed A5, stepping every edge.
    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 8'hA5;
        else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.key_pos = 4'hF;
        #7;
        rst = 1'b0;
    endtask

    task automatic do_start;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Ticks up to a spawn edge; h is the target read from the reference just before it.
    task automatic spawn_step(input int pre, output int h);
        repeat (pre - 1) tick();
        h = int'(m_lfsr) % 9;
        tick();
    endtask

    task automatic test_reset;
        #1;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.key_pos = 4'hF;
        #2;
        vectors++; if (bus.game_state !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", bus.game_state); end
        vectors++; if (bus.mole_map !== 9'd0) begin miscompares++; $display("FAIL reset_map: got %h expected 000", bus.mole_map); end
        vectors++; if (bus.score !== 10'd0 || bus.miss_cnt !== 4'd0) begin miscompares++; $display("FAIL reset_counts: got score %0d miss %0d expected 0 0", bus.score, bus.miss_cnt); end
        vectors++; if (bus.hit_pulse !== 1'b0 || bus.miss_pulse !== 1'b0) begin miscompares++; $display("FAIL reset_pulses: got %b%b expected 00", bus.hit_pulse, bus.miss_pulse); end
        #5;
        rst = 1'b0;
        bus.key_pos = 4'd0;
        repeat (6) tick();
        bus.key_pos = 4'hF;
        vectors++; if (bus.game_state !== 2'd0 || bus.score !== 10'd0) begin miscompares++; $display("FAIL idle_hold: got state %0d score %0d expected 0 0", bus.game_state, bus.score); end
    endtask

    task automatic test_spawn_hit;
        int h;
        logic [8:0] exp_map;
        apply_reset();
        do_start();
        vectors++; if (bus.game_state !== 2'd1) begin miscompares++; $display("FAIL start_play: got %0d expected 1", bus.game_state); end
        spawn_step(4, h);
        exp_map = '0;
        exp_map[h] = 1'b1;
        vectors++; if (bus.mole_map !== exp_map) begin miscompares++; $display("FAIL first_spawn: got %h expected %h", bus.mole_map, exp_map); end
        bus.key_pos = 4'(h);
        tick();
        bus.key_pos = 4'hF;
        vectors++; if (bus.mole_map[h] !== 1'b0) begin miscompares++; $display("FAIL hit_clear: got %b expected 0", bus.mole_map[h]); end
        vectors++; if (bus.score !== 10'd1) begin miscompares++; $display("FAIL hit_score: got %0d expected 1", bus.score); end
        vectors++; if (bus.hit_pulse !== 1'b1) begin miscompares++; $display("FAIL hit_pulse_hi: got %b expected 1", bus.hit_pulse); end
        tick();
        vectors++; if (bus.hit_pulse !== 1'b0) begin miscompares++; $display("FAIL hit_pulse_lo: got %b expected 0", bus.hit_pulse); end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        vectors++; if (bus.score !== 10'd1 || bus.game_state !== 2'd1) begin miscompares++; $display("FAIL start_in_play: got score %0d state %0d expected 1 1", bus.score, bus.game_state); end
    endtask

    task automatic test_expiry;
        int h;
        apply_reset();
        do_start();
        spawn_step(4, h);
        repeat (7) tick();
        vectors++; if (bus.mole_map[h] !== 1'b1 || bus.miss_cnt !== 4'd0) begin miscompares++; $display("FAIL pre_expiry: got bit %b miss %0d expected 1 0", bus.mole_map[h], bus.miss_cnt); end
        tick();
        vectors++; if (bus.mole_map[h] !== 1'b0) begin miscompares++; $display("FAIL expiry_clear: got %b expected 0", bus.mole_map[h]); end
        vectors++; if (bus.miss_cnt !== 4'd1 || bus.miss_pulse !== 1'b1) begin miscompares++; $display("FAIL expiry_miss: got miss %0d pulse %b expected 1 1", bus.miss_cnt, bus.miss_pulse); end
        tick();
        vectors++; if (bus.miss_pulse !== 1'b0 || bus.miss_cnt !== 4'd1) begin miscompares++; $display("FAIL expiry_pulse_lo: got pulse %b miss %0d expected 0 1", bus.miss_pulse, bus.miss_cnt); end
    endtask

    task automatic test_game_over;
        int pulses;
        bit done;
        apply_reset();
        do_start();
        pulses = 0;
        done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            tick();
            if (bus.miss_pulse === 1'b1) pulses++;
            if (bus.game_state === 2'd2) done = 1'b1;
        end
        vectors++; if (!done) begin miscompares++; $display("FAIL over_timeout: got state %0d expected 2", bus.game_state); end
        vectors++; if (bus.mole_map !== 9'd0) begin miscompares++; $display("FAIL over_map: got %h expected 000", bus.mole_map); end
        vectors++; if (bus.miss_cnt !== 4'd3 || bus.score !== 10'd0 || pulses != 3) begin miscompares++; $display("FAIL over_counts: got miss %0d score %0d pulses %0d expected 3 0 3", bus.miss_cnt, bus.score, pulses); end
        for (int k = 0; k < 9; k++) begin
            bus.key_pos = 4'(k);
            tick();
        end
        bus.key_pos = 4'hF;
        vectors++; if (bus.game_state !== 2'd2 || bus.score !== 10'd0 || bus.miss_cnt !== 4'd3 || bus.mole_map !== 9'd0) begin miscompares++; $display("FAIL over_frozen: got state %0d score %0d miss %0d map %h expected 2 0 3 000", bus.game_state, bus.score, bus.miss_cnt, bus.mole_map); end
        do_start();
        vectors++; if (bus.game_state !== 2'd1 || bus.score !== 10'd0 || bus.miss_cnt !== 4'd0) begin miscompares++; $display("FAIL restart: got state %0d score %0d miss %0d expected 1 0 0", bus.game_state, bus.score, bus.miss_cnt); end
    endtask

    task automatic test_collision;
        int h;
        int e;
        apply_reset();
        do_start();
        spawn_step(4, h);
        repeat (7) tick();
        bus.key_pos = 4'(h);
        tick();
        bus.key_pos = 4'hF;
        vectors++; if (bus.score !== 10'd1 || bus.hit_pulse !== 1'b1) begin miscompares++; $display("FAIL collide_hit: got score %0d pulse %b expected 1 1", bus.score, bus.hit_pulse); end
        vectors++; if (bus.miss_cnt !== 4'd0 || bus.miss_pulse !== 1'b0) begin miscompares++; $display("FAIL collide_nomiss: got miss %0d pulse %b expected 0 0", bus.miss_cnt, bus.miss_pulse); end
        vectors++; if (bus.mole_map[h] !== 1'b0) begin miscompares++; $display("FAIL collide_clear: got %b expected 0", bus.mole_map[h]); end
        bus.key_pos = 4'hF;
        tick();
        vectors++; if (bus.score !== 10'd1 || bus.hit_pulse !== 1'b0) begin miscompares++; $display("FAIL key15: got score %0d pulse %b expected 1 0", bus.score, bus.hit_pulse); end
        bus.key_pos = 4'd9;
        tick();
        vectors++; if (bus.score !== 10'd1 || bus.hit_pulse !== 1'b0) begin miscompares++; $display("FAIL key9: got score %0d pulse %b expected 1 0", bus.score, bus.hit_pulse); end
        e = 0;
        while (e < 8 && bus.mole_map[e] !== 1'b0) e++;
        bus.key_pos = 4'(e);
        tick();
        bus.key_pos = 4'hF;
        vectors++; if (bus.score !== 10'd1 || bus.hit_pulse !== 1'b0 || bus.miss_cnt !== 4'd0 || bus.mole_map[e] !== 1'b0) begin miscompares++; $display("FAIL empty_key: got score %0d pulse %b miss %0d bit %b expected 1 0 0 0", bus.score, bus.hit_pulse, bus.miss_cnt, bus.mole_map[e]); end
    endtask

    task automatic test_saturation_reset;
        int h;
        logic [8:0] exp_map;
        apply_reset();
        do_start();
        spawn_step(4, h);
        for (int n = 0; n < 999; n++) begin
            bus.key_pos = 4'(h);
            tick();
            bus.key_pos = 4'hF;
            spawn_step(3, h);
        end
        exp_map = '0;
        exp_map[h] = 1'b1;
        vectors++; if (bus.score !== 10'd999 || bus.mole_map !== exp_map) begin miscompares++; $display("FAIL score_999: got score %0d map %h expected 999 %h", bus.score, bus.mole_map, exp_map); end
        bus.key_pos = 4'(h);
        tick();
        bus.key_pos = 4'hF;
        vectors++; if (bus.score !== 10'd999 || bus.hit_pulse !== 1'b1) begin miscompares++; $display("FAIL score_sat: got score %0d pulse %b expected 999 1", bus.score, bus.hit_pulse); end
        spawn_step(3, h);
        bus.key_pos = 4'(h);
        #2;
        rst = 1'b1;
        #1;
        vectors++; if (bus.game_state !== 2'd0 || bus.mole_map !== 9'd0 || bus.score !== 10'd0 || bus.miss_cnt !== 4'd0) begin miscompares++; $display("FAIL async_rst: got state %0d map %h score %0d miss %0d expected 0 000 0 0", bus.game_state, bus.mole_map, bus.score, bus.miss_cnt); end
        vectors++; if (bus.hit_pulse !== 1'b0 || bus.miss_pulse !== 1'b0) begin miscompares++; $display("FAIL async_rst_pulse: got %b%b expected 00", bus.hit_pulse, bus.miss_pulse); end
        bus.key_pos = 4'hF;
        #3;
        rst = 1'b0;
        repeat (3) tick();
        vectors++; if (bus.game_state !== 2'd0 || bus.score !== 10'd0 || bus.hit_pulse !== 1'b0) begin miscompares++; $display("FAIL post_rst_idle: got state %0d score %0d pulse %b expected 0 0 0", bus.game_state, bus.score, bus.hit_pulse); end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.key_pos = 4'hF;
        test_reset();
        test_spawn_hit();
        test_expiry();
        test_game_over();
        test_collision();
        test_saturation_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
